// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle of the reset sequencer.
// The master side issues soft-reset requests and watchdog kicks and observes
// the per-domain resets plus status; the slave side is the sequencer itself.
interface rst_seq_ctrl_if #(
  parameter int N_CH = 4
);
  logic            soft_rst_req;
  logic            wdt_kick;
  logic [N_CH-1:0] rst_out;
  logic            all_ready;
  logic            busy;
  logic [1:0]      rst_cause;

  modport master (
    output soft_rst_req,
    output wdt_kick,
    input  rst_out,
    input  all_ready,
    input  busy,
    input  rst_cause
  );

  modport slave (
    input  soft_rst_req,
    input  wdt_kick,
    output rst_out,
    output all_ready,
    output busy,
    output rst_cause
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and watchdog.
// Keeps all N_CH reset domains asserted for HOLD_CYCLES after the reset source
// goes away, then releases them one by one (bit 0 first) with STAGE_GAP cycles
// between releases. A soft request or a watchdog timeout re-runs the sequence.
// The cause of the most recent reset is kept in rst_cause. All outputs are
// driven straight from registers.
module rst_seq_ctrl #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_EN      = 1,
  parameter int WDT_CYCLES  = 64,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  rst_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] WDT_LAST   = CNT_W'(WDT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [N_CH-1:0]  ALL_ASSERTED = {N_CH{1'b1}};

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  // Registered state
  state_t           state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] stage_idx_r;
  logic [CNT_W-1:0] gap_cnt_r;
  logic [CNT_W-1:0] wdt_cnt_r;
  logic [N_CH-1:0]  rst_out_r;
  logic             all_ready_r;
  logic             busy_r;
  logic [1:0]       rst_cause_r;

  // Next-state values
  state_t           state_s;
  logic [CNT_W-1:0] hold_cnt_s;
  logic [CNT_W-1:0] stage_idx_s;
  logic [CNT_W-1:0] gap_cnt_s;
  logic [CNT_W-1:0] wdt_cnt_s;
  logic [N_CH-1:0]  rst_out_s;
  logic             all_ready_s;
  logic             busy_s;
  logic [1:0]       rst_cause_s;

  logic             wdt_timeout_s;

  // Deassert one domain; every other bit is passed through unchanged, so a
  // release can only ever move a single bit from 1 to 0.
  function automatic logic [N_CH-1:0] clear_bit(input logic [N_CH-1:0] vec,
                                                input logic [CNT_W-1:0] idx);
    logic [N_CH-1:0] res;
    for (int i = 0; i < N_CH; i++) begin
      res[i] = vec[i] & ~(CNT_W'(i) == idx);
    end
    return res;
  endfunction

  // Watchdog timeout: last unkicked RUN edge before the limit; a kick on the
  // same edge cancels it, and with the watchdog disabled it never fires.
  always_comb begin
    wdt_timeout_s = 1'b0;
    if (WDT_EN != 0) begin
      wdt_timeout_s = (state_r == ST_RUN) && (wdt_cnt_r == WDT_LAST) && !bus.wdt_kick;
    end else begin
      wdt_timeout_s = 1'b0;
    end
  end

  // Next-state and output computation: sequencing first, restarts override.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    stage_idx_s = stage_idx_r;
    gap_cnt_s   = gap_cnt_r;
    wdt_cnt_s   = wdt_cnt_r;
    rst_out_s   = rst_out_r;
    all_ready_s = all_ready_r;
    busy_s      = busy_r;
    rst_cause_s = rst_cause_r;

    case (state_r)
      ST_ASSERT: begin
        hold_cnt_s = hold_cnt_r + CNT_ONE;
        if (hold_cnt_r == HOLD_LAST) begin
          rst_out_s = clear_bit(rst_out_r, CNT_ZERO);
          if (N_CH == 1) begin
            state_s     = ST_RUN;
            all_ready_s = 1'b1;
            busy_s      = 1'b0;
            wdt_cnt_s   = CNT_ZERO;
          end else begin
            state_s     = ST_RELEASE;
            stage_idx_s = CNT_ONE;
            gap_cnt_s   = CNT_ZERO;
          end
        end else begin
          rst_out_s = rst_out_r;
        end
      end

      ST_RELEASE: begin
        if (gap_cnt_r == GAP_LAST) begin
          rst_out_s   = clear_bit(rst_out_r, stage_idx_r);
          stage_idx_s = stage_idx_r + CNT_ONE;
          gap_cnt_s   = CNT_ZERO;
          if (stage_idx_r == STAGE_LAST) begin
            state_s     = ST_RUN;
            all_ready_s = 1'b1;
            busy_s      = 1'b0;
            wdt_cnt_s   = CNT_ZERO;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          gap_cnt_s = gap_cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (WDT_EN == 0) begin
          wdt_cnt_s = CNT_ZERO;
        end else if (bus.wdt_kick) begin
          wdt_cnt_s = CNT_ZERO;
        end else begin
          wdt_cnt_s = wdt_cnt_r + CNT_ONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a fully asserted restart.
        state_s     = ST_ASSERT;
        rst_out_s   = ALL_ASSERTED;
        hold_cnt_s  = CNT_ZERO;
        stage_idx_s = CNT_ZERO;
        gap_cnt_s   = CNT_ZERO;
        all_ready_s = 1'b0;
        busy_s      = 1'b1;
      end
    endcase

    // Restart events; soft request wins over a coincident timeout.
    if (bus.soft_rst_req || wdt_timeout_s) begin
      state_s     = ST_ASSERT;
      rst_out_s   = ALL_ASSERTED;
      hold_cnt_s  = CNT_ZERO;
      stage_idx_s = CNT_ZERO;
      gap_cnt_s   = CNT_ZERO;
      all_ready_s = 1'b0;
      busy_s      = 1'b1;
      if (bus.soft_rst_req) begin
        rst_cause_s = CAUSE_SOFT;
      end else begin
        rst_cause_s = CAUSE_WDT;
      end
    end else begin
      rst_cause_s = rst_cause_s;
    end
  end

  // State register with synchronous external reset taking top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ASSERT;
      hold_cnt_r  <= CNT_ZERO;
      stage_idx_r <= CNT_ZERO;
      gap_cnt_r   <= CNT_ZERO;
      wdt_cnt_r   <= CNT_ZERO;
      rst_out_r   <= ALL_ASSERTED;
      all_ready_r <= 1'b0;
      busy_r      <= 1'b1;
      rst_cause_r <= CAUSE_EXT;
    end else begin
      state_r     <= state_s;
      hold_cnt_r  <= hold_cnt_s;
      stage_idx_r <= stage_idx_s;
      gap_cnt_r   <= gap_cnt_s;
      wdt_cnt_r   <= wdt_cnt_s;
      rst_out_r   <= rst_out_s;
      all_ready_r <= all_ready_s;
      busy_r      <= busy_s;
      rst_cause_r <= rst_cause_s;
    end
  end

  assign bus.rst_out   = rst_out_r;
  assign bus.all_ready = all_ready_r;
  assign bus.busy      = busy_r;
  assign bus.rst_cause = rst_cause_r;

endmodule
